color_shift_sequencer: RTL and testbench

- Avalon-MM slave that owns the red/green/blue colour-shift values feeding the pixel shader.
- Replaces three free-running PIO registers, which let HPS writes tear mid-frame, with shadow target registers.
- Targets are committed atomically at the next frame_start, either instantly or as a ±1-per-frame ramp.
- Sits between the HPS lightweight bridge and the VGA/shader datapath.

---
 rtl/color_shift_pkg.sv | 25 ++
 rtl/shift_stepper.sv | 25 ++
 rtl/color_shift_sequencer.sv | 149 ++++++++++++++
 tb/tb_color_shift_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/color_shift_pkg.sv
// rtl/color_shift_pkg.sv - shared types and register map for the colour-shift sequencer
package color_shift_pkg;

  // Apply sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RAMP  = 2'd2
  } state_e;

  // Register word addresses
  localparam logic [2:0] ADDR_R_TGT     = 3'd0;
  localparam logic [2:0] ADDR_G_TGT     = 3'd1;
  localparam logic [2:0] ADDR_B_TGT     = 3'd2;
  localparam logic [2:0] ADDR_CTRL      = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE    = 3'd4;
  localparam logic [2:0] ADDR_FRAME_CNT = 3'd5;

  // CTRL bit positions
  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_RAMP_EN_BIT = 1;
  localparam int CTRL_ARMED_BIT   = 2;
  localparam int CTRL_RAMPING_BIT = 3;

endpackage

// File: rtl/shift_stepper.sv
// rtl/shift_stepper.sv - moves one channel value one step toward its target
module shift_stepper #(
  parameter int W = 5
) (
  input  logic [W-1:0] cur_i,
  input  logic [W-1:0] tgt_i,
  input  logic         step_en_i,
  output logic [W-1:0] next_o,
  output logic         done_o
);

  // Unsigned compare, +1 below / -1 above / hold when equal; never wraps
  always_comb begin
    next_o = cur_i;
    if (step_en_i) begin
      if (cur_i < tgt_i) begin
        next_o = cur_i + W'(1);
      end else if (cur_i > tgt_i) begin
        next_o = cur_i - W'(1);
      end
    end
    done_o = (next_o == tgt_i);
  end

endmodule

// File: rtl/color_shift_sequencer.sv
// rtl/color_shift_sequencer.sv - shadowed RGB shift registers applied atomically at frame start
module color_shift_sequencer
  import color_shift_pkg::*;
#(
  parameter int SHIFT_W = 5,
  parameter int FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic               frame_start,
  output logic [SHIFT_W-1:0] red_shift,
  output logic [SHIFT_W-1:0] green_shift,
  output logic [SHIFT_W-1:0] blue_shift,
  output logic               busy
);

  state_e              state_q, state_d;
  logic [SHIFT_W-1:0]  tgt_q  [3];
  logic [SHIFT_W-1:0]  snap_q [3];
  logic [SHIFT_W-1:0]  act_q  [3];
  logic [SHIFT_W-1:0]  step_next [3];
  logic [2:0]          done;
  logic                all_done;
  logic                ramp_en_q;
  logic                rearm_q;
  logic [FCNT_W-1:0]   fcnt_q;
  logic                wr, commit;
  logic                step_now, apply_now, snap_now, ramp_exit;
  logic                unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign commit       = wr && (address == ADDR_CTRL) && writedata[CTRL_COMMIT_BIT];
  assign step_now     = (state_q == RAMP) && frame_start;
  assign all_done     = &done;
  assign unused_wdata = ^writedata[31:SHIFT_W];

  assign red_shift   = act_q[0];
  assign green_shift = act_q[1];
  assign blue_shift  = act_q[2];

  for (genvar i = 0; i < 3; i++) begin : g_step
    shift_stepper #(.W(SHIFT_W)) u_step (
      .cur_i     (act_q[i]),
      .tgt_i     (snap_q[i]),
      .step_en_i (step_now),
      .next_o    (step_next[i]),
      .done_o    (done[i])
    );
  end

  // Host-visible shadow targets and ramp enable
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) tgt_q[i] <= '0;
      ramp_en_q <= 1'b0;
    end else if (wr) begin
      case (address)
        ADDR_R_TGT: tgt_q[0]  <= writedata[SHIFT_W-1:0];
        ADDR_G_TGT: tgt_q[1]  <= writedata[SHIFT_W-1:0];
        ADDR_B_TGT: tgt_q[2]  <= writedata[SHIFT_W-1:0];
        ADDR_CTRL:  ramp_en_q <= writedata[CTRL_RAMP_EN_BIT];
        default: ;
      endcase
    end
  end

  // Free-running frame counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
    end else if (frame_start) begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a commit that lands with the final ramp step still re-arms
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit) state_d = ARMED;
      ARMED:   if (frame_start) state_d = ramp_en_q ? RAMP : IDLE;
      RAMP:    if (frame_start && all_done) state_d = (rearm_q || commit) ? ARMED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state strobes for the datapath
  always_comb begin
    busy      = (state_q != IDLE);
    apply_now = (state_q == ARMED) && frame_start && !ramp_en_q;
    snap_now  = (state_q == ARMED) && frame_start && ramp_en_q;
    ramp_exit = step_now && all_done;
  end

  // Active shifts, ramp snapshot and pending re-arm; targets used here are pre-write values
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        act_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      rearm_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (apply_now) act_q[i] <= tgt_q[i];
        if (step_now)  act_q[i] <= step_next[i];
        if (snap_now)  snap_q[i] <= tgt_q[i];
      end
      if (ramp_exit) begin
        rearm_q <= 1'b0;
      end else if ((state_q == RAMP) && commit) begin
        rearm_q <= 1'b1;
      end
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_R_TGT:     readdata[SHIFT_W-1:0] = tgt_q[0];
      ADDR_G_TGT:     readdata[SHIFT_W-1:0] = tgt_q[1];
      ADDR_B_TGT:     readdata[SHIFT_W-1:0] = tgt_q[2];
      ADDR_CTRL: begin
        readdata[CTRL_RAMP_EN_BIT] = ramp_en_q;
        readdata[CTRL_ARMED_BIT]   = (state_q == ARMED);
        readdata[CTRL_RAMPING_BIT] = (state_q == RAMP);
      end
      ADDR_ACTIVE:    readdata[3*SHIFT_W-1:0] = {act_q[2], act_q[1], act_q[0]};
      ADDR_FRAME_CNT: readdata[FCNT_W-1:0] = fcnt_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_color_shift_sequencer.sv
// tb/tb_color_shift_sequencer.sv - randomized and directed checks against a behavioural model
module tb_color_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        frame_start = 1'b0;
  logic [4:0]  red_shift, green_shift, blue_shift;
  logic        busy;

  int checks = 0;
  int passes = 0;
  bit check_en = 1'b0;

  bit [4:0]  m_tgt [3];
  bit [4:0]  m_act [3];
  bit [4:0]  m_snap [3];
  bit        m_ramp_en, m_rearm, m_waiting, m_ramping;
  bit [15:0] m_fcnt;

  color_shift_sequencer #(.SHIFT_W(5), .FCNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .frame_start (frame_start),
    .red_shift   (red_shift),
    .green_shift (green_shift),
    .blue_shift  (blue_shift),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return 32'(m_tgt[a]);
      3'd3: return {28'd0, m_ramping, m_waiting, m_ramp_en, 1'b0};
      3'd4: return {17'd0, m_act[2], m_act[1], m_act[0]};
      3'd5: return {16'd0, m_fcnt};
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural model: one call per clock, using the inputs the DUT sampled
  task automatic model_step();
    bit w, commit, all_eq;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_tgt[i] = 0; m_act[i] = 0; m_snap[i] = 0;
      end
      m_ramp_en = 0; m_rearm = 0; m_waiting = 0; m_ramping = 0; m_fcnt = 0;
      return;
    end
    w = chipselect && !write_n;
    commit = w && address == 3'd3 && writedata[0];
    if (frame_start) m_fcnt = m_fcnt + 16'd1;
    if (m_ramping) begin
      if (commit) m_rearm = 1;
      if (frame_start) begin
        all_eq = 1;
        for (int i = 0; i < 3; i++) begin
          if (m_act[i] < m_snap[i]) m_act[i] = m_act[i] + 5'd1;
          else if (m_act[i] > m_snap[i]) m_act[i] = m_act[i] - 5'd1;
          if (m_act[i] != m_snap[i]) all_eq = 0;
        end
        if (all_eq) begin
          m_ramping = 0;
          if (m_rearm) begin
            m_waiting = 1;
            m_rearm = 0;
          end
        end
      end
    end else if (m_waiting) begin
      if (frame_start) begin
        m_waiting = 0;
        if (m_ramp_en) begin
          for (int i = 0; i < 3; i++) m_snap[i] = m_tgt[i];
          m_ramping = 1;
        end else begin
          for (int i = 0; i < 3; i++) m_act[i] = m_tgt[i];
        end
      end
    end else if (commit) begin
      m_waiting = 1;
    end
    if (w) begin
      if (address <= 3'd2) m_tgt[address] = writedata[4:0];
      else if (address == 3'd3) m_ramp_en = writedata[1];
    end
  endtask

  // Continuous comparison of every output against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("red_shift", 32'(red_shift), 32'(m_act[0]));
      chk("green_shift", 32'(green_shift), 32'(m_act[1]));
      chk("blue_shift", 32'(blue_shift), 32'(m_act[2]));
      chk("busy", 32'(busy), 32'(m_waiting | m_ramping));
      chk("readdata", readdata, exp_rd(address));
    end
  end

  task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic fs, input logic rst);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    frame_start = fs; reset = rst;
    @(posedge clk);
    model_step();
    #1;
    chipselect = 1'b0; write_n = 1'b1; frame_start = 1'b0; reset = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic frame();
    cyc(address, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(address, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  task automatic outs(input int r, input int g, input int b, input int bz, input string name);
    chk({name, "_r"}, 32'(red_shift), 32'(r));
    chk({name, "_g"}, 32'(green_shift), 32'(g));
    chk({name, "_b"}, 32'(blue_shift), 32'(b));
    chk({name, "_busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    cyc(3'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    cyc(3'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    check_en = 1'b1;

    outs(0, 0, 0, 0, "reset");
    rd(3'd0, 32'd0, "reset_rtgt");
    rd(3'd3, 32'd0, "reset_ctrl");
    rd(3'd4, 32'd0, "reset_active");
    rd(3'd5, 32'd0, "reset_fcnt");
    rd(3'd7, 32'd0, "reset_addr7");

    // Instant apply
    wr_reg(3'd0, 32'd5);
    wr_reg(3'd1, 32'd10);
    wr_reg(3'd2, 32'hABCD_001F);
    wr_reg(3'd3, 32'd1);
    idle(20);
    outs(0, 0, 0, 1, "armed_wait");
    rd(3'd3, 32'h4, "ctrl_armed");
    frame();
    outs(5, 10, 31, 0, "instant");
    rd(3'd4, 32'h0000_7D45, "active_packed");
    rd(3'd2, 32'd31, "btgt_masked");

    // Ramp 5/10/31 -> 8/10/29
    wr_reg(3'd0, 32'd8);
    wr_reg(3'd2, 32'd29);
    wr_reg(3'd3, 32'd3);
    frame();
    outs(5, 10, 31, 1, "ramp_entry");
    rd(3'd3, 32'hA, "ctrl_ramping");
    idle(3);
    frame(); outs(6, 10, 30, 1, "ramp_f2");
    frame(); outs(7, 10, 29, 1, "ramp_f3");
    frame(); outs(8, 10, 29, 0, "ramp_f4");
    rd(3'd3, 32'h2, "ctrl_idle_ramp_en");
    frame(); outs(8, 10, 29, 0, "ramp_f5");

    // Commit during a ramp re-arms after it completes
    wr_reg(3'd0, 32'd10);
    wr_reg(3'd3, 32'd3);
    frame();
    wr_reg(3'd0, 32'd0);
    wr_reg(3'd3, 32'd3);
    frame(); outs(9, 10, 29, 1, "rearm_step1");
    frame(); outs(10, 10, 29, 1, "rearm_step2");
    rd(3'd3, 32'h6, "ctrl_rearmed");
    frame(); outs(10, 10, 29, 1, "rearm_entry");
    frame(); frame(); frame();
    outs(7, 10, 29, 1, "ramp_down");

    // Reset mid-ramp
    cyc(3'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    outs(0, 0, 0, 0, "mid_reset");
    rd(3'd3, 32'd0, "mid_reset_ctrl");
    rd(3'd5, 32'd0, "mid_reset_fcnt");

    // Commit coincident with frame_start in IDLE
    wr_reg(3'd0, 32'd3);
    cyc(3'd3, 1'b1, 1'b0, 32'd1, 1'b1, 1'b0);
    outs(0, 0, 0, 1, "commit_fs_same");
    frame();
    outs(3, 0, 0, 0, "commit_fs_next");

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 4000; i++) begin
      cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 399) == 0));
    end

    // Frame counter wrap
    cyc(3'd5, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) frame();
    rd(3'd5, 32'h0000_FFFF, "fcnt_max");
    frame();
    rd(3'd5, 32'd0, "fcnt_wrap");

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
